tb_vip_slave: RTL and testbench



---
 rtl/cross_bar_pkg.sv | 19 +
 rtl/tb_vip_slave_if.sv | 21 ++
 rtl/tb_vip_slave_mem.sv | 39 +++
 rtl/tb_vip_slave.sv | 141 ++++++++++++++
 tb/tb_tb_vip_slave.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cross_bar_pkg.sv
// rtl/cross_bar_pkg.sv - cross-bar shared types plus slave VIP command and FSM definitions
package cross_bar_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam logic CMD_WR = 1'b1;
   localparam logic CMD_RD = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } slv_state_e;

endpackage

// File: rtl/tb_vip_slave_if.sv
// rtl/tb_vip_slave_if.sv - cross-bar slave port request/ack bundle
import cross_bar_pkg::*;

interface tb_vip_slave_if;
   logic  slave_req;
   addr_t slave_addr;
   logic  slave_cmd;
   data_t slave_wdata;
   logic  slave_ack;
   data_t slave_rdata;

   modport master (
      output slave_req, slave_addr, slave_cmd, slave_wdata,
      input  slave_ack, slave_rdata
   );

   modport slave (
      input  slave_req, slave_addr, slave_cmd, slave_wdata,
      output slave_ack, slave_rdata
   );
endinterface

// File: rtl/tb_vip_slave_mem.sv
// rtl/tb_vip_slave_mem.sv - word memory, synchronous write, registered read port
// Contents are never reset; only the read register is, so rdata idles at zero.
module tb_vip_slave_mem
   import cross_bar_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  data_t            wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] raddr_i,
   output data_t            rdata_o
);

   data_t mem_q [MEM_DEPTH];
   data_t rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data is held only for the cycle after a read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= re_i ? mem_q[raddr_i] : '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tb_vip_slave.sv
// rtl/tb_vip_slave.sv - bench responder for a cross-bar slave port with configurable ack wait
// Optional TB_VIP_SLAVE_RAND_LAT_EN: per-request wait drawn from an LFSR, bounded by cfg_latency.
module tb_vip_slave
   import cross_bar_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int LAT_W     = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             aresetn,
   tb_vip_slave_if.slave    bus,
   input  logic [LAT_W-1:0] cfg_latency,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] rd_cnt,
   output logic             proto_err
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   slv_state_e       state_q, state_d;
   logic [LAT_W-1:0] wait_q, wait_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cmd_q, cmd_d;
   data_t            wdata_q, wdata_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             err_q, err_d;
   logic [LAT_W-1:0] eff_lat;
   logic             mem_we, mem_re;

`ifdef TB_VIP_SLAVE_RAND_LAT_EN
   logic [15:0]  lfsr_q;
   logic [LAT_W:0] lat_mod;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_comb begin
      lat_mod = {1'b0, lfsr_q[LAT_W-1:0]} % ({1'b0, cfg_latency} + (LAT_W+1)'(1));
      eff_lat = lat_mod[LAT_W-1:0];
   end
`else
   assign eff_lat = cfg_latency;
`endif

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         idx_q    <= '0;
         cmd_q    <= CMD_RD;
         wdata_q  <= '0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         idx_q    <= idx_d;
         cmd_q    <= cmd_d;
         wdata_q  <= wdata_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      idx_d    = idx_q;
      cmd_d    = cmd_q;
      wdata_d  = wdata_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (bus.slave_req) begin
               idx_d   = bus.slave_addr[IDX_W-1:0];
               cmd_d   = bus.slave_cmd;
               wdata_d = bus.slave_wdata;
               wait_d  = eff_lat;
               state_d = (eff_lat == '0) ? ACK : WAIT;
            end
         end
         WAIT: begin
            // Request withdrawn before completion: abandon without touching memory.
            if (!bus.slave_req) begin
               err_d   = 1'b1;
               wait_d  = '0;
               state_d = IDLE;
            end else begin
               wait_d = wait_q - LAT_W'(1);
               if (wait_q == LAT_W'(1)) begin
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
            if (cmd_q == CMD_WR) begin
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end else begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read is launched on the edge entering ACK so data lines up with the ack cycle.
   assign mem_re = (state_d == ACK) && (cmd_d == CMD_RD);
   assign mem_we = (state_q == ACK) && (cmd_q == CMD_WR);

   tb_vip_slave_mem #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (aresetn),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .re_i    (mem_re),
      .raddr_i (idx_d),
      .rdata_o (bus.slave_rdata)
   );

   assign bus.slave_ack = (state_q == ACK);
   assign wr_cnt        = wr_cnt_q;
   assign rd_cnt        = rd_cnt_q;
   assign proto_err     = err_q;

endmodule

// File: tb/tb_tb_vip_slave.sv
// tb/tb_tb_vip_slave.sv - self-checking bench for tb_vip_slave against a transaction-level model
module tb_tb_vip_slave;
   import cross_bar_pkg::*;

   localparam int MEM_DEPTH = 256;
   localparam int LAT_W     = 4;
   localparam int CNT_W     = 16;
   localparam int IDX_W     = $clog2(MEM_DEPTH);

   logic             clk = 1'b0;
   logic             aresetn = 1'b0;
   logic [LAT_W-1:0] cfg_latency = '0;
   logic [CNT_W-1:0] wr_cnt, rd_cnt;
   logic             proto_err;

   tb_vip_slave_if bus();

   tb_vip_slave #(
      .MEM_DEPTH (MEM_DEPTH),
      .LAT_W     (LAT_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .bus         (bus),
      .cfg_latency (cfg_latency),
      .wr_cnt      (wr_cnt),
      .rd_cnt      (rd_cnt),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    checks = 0;
   int    errors = 0;
   data_t ref_mem [int];
   int    exp_wr = 0;
   int    exp_rd = 0;
   bit    exp_err = 1'b0;

   function automatic int idx_of(input addr_t a);
      return int'(a) & (MEM_DEPTH - 1);
   endfunction

   task automatic check_counters(input string tag);
      checks++;
      if (wr_cnt !== CNT_W'(exp_wr) || rd_cnt !== CNT_W'(exp_rd) || proto_err !== exp_err) begin
         errors++;
         $display("FAIL %s counters: wr=%0d rd=%0d err=%0b expected wr=%0d rd=%0d err=%0b",
                  tag, wr_cnt, rd_cnt, proto_err, CNT_W'(exp_wr), CNT_W'(exp_rd), exp_err);
      end
   endtask

   task automatic do_txn(input logic cmd, input addr_t addr, input data_t data, input int lat,
                         input string tag);
      int    req_cyc, n, idx;
      bit    seen;
      data_t got;
      idx = idx_of(addr);
      @(posedge clk); #1;
      cfg_latency       = lat[LAT_W-1:0];
      bus.slave_req     = 1'b1;
      bus.slave_cmd     = cmd;
      bus.slave_addr    = addr;
      bus.slave_wdata   = data;
      req_cyc = cyc;
      seen = 1'b0;
      n = 0;
      got = '0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.slave_ack === 1'b1) begin
            seen = 1'b1;
            got  = bus.slave_rdata;
         end
      end
      checks++;
      if (!seen || (cyc - req_cyc) != lat + 1) begin
         errors++;
         $display("FAIL %s latency: acked=%0b after %0d cycles expected %0d", tag, seen,
                  cyc - req_cyc, lat + 1);
      end
      if (seen) begin
         if (cmd == CMD_WR) begin
            checks++;
            if (got !== '0) begin
               errors++;
               $display("FAIL %s write rdata: got %h expected 0", tag, got);
            end
            ref_mem[idx] = data;
            exp_wr++;
         end else begin
            if (ref_mem.exists(idx)) begin
               checks++;
               if (got !== ref_mem[idx]) begin
                  errors++;
                  $display("FAIL %s rdata: got %h expected %h", tag, got, ref_mem[idx]);
               end
            end
            exp_rd++;
         end
      end
      @(posedge clk); #1;
      bus.slave_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.slave_ack !== 1'b0 || bus.slave_rdata !== '0) begin
         errors++;
         $display("FAIL %s ack pulse: ack=%0b rdata=%h after ack cycle, expected 0/0", tag,
                  bus.slave_ack, bus.slave_rdata);
      end
      check_counters(tag);
   endtask

   task automatic test_reset();
      bus.slave_req = 1'b0; bus.slave_cmd = CMD_RD; bus.slave_addr = '0; bus.slave_wdata = '0;
      aresetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.slave_ack !== 1'b0 || bus.slave_rdata !== '0 || wr_cnt !== '0 || rd_cnt !== '0 ||
          proto_err !== 1'b0) begin
         errors++;
         $display("FAIL reset: ack=%0b rdata=%h wr=%0d rd=%0d err=%0b expected all zero",
                  bus.slave_ack, bus.slave_rdata, wr_cnt, rd_cnt, proto_err);
      end
      aresetn = 1'b1;
   endtask

   task automatic test_write_read();
      do_txn(CMD_WR, 32'h10, 32'hDEADBEEF, 0, "wr_0x10");
      do_txn(CMD_RD, 32'h10, '0, 0, "rd_0x10");
   endtask

   task automatic test_latency();
      do_txn(CMD_RD, 32'h10, '0, 3, "lat3");
      do_txn(CMD_RD, 32'h10, '0, 15, "lat15");
      do_txn(CMD_WR, 32'h11, 32'h1234_5678, 15, "lat15_wr");
   endtask

   task automatic test_alias();
      do_txn(CMD_WR, 32'h005, 32'h55, 0, "alias_wr");
      do_txn(CMD_RD, 32'h105, '0, 2, "alias_rd");
      do_txn(CMD_RD, 32'hFFFF_FF05, '0, 0, "alias_rd_hi");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         addr_t a;
         logic  c;
         a = addr_t'($urandom_range(0, 15)) | (addr_t'($urandom_range(0, 7)) << 8);
         c = ($urandom_range(0, 1) == 1) ? CMD_WR : CMD_RD;
         do_txn(c, a, data_t'($urandom), int'($urandom_range(0, 7)), "random");
      end
   endtask

   task automatic test_proto_err();
      int acks;
      do_txn(CMD_WR, 32'h30, 32'hCAFE_0030, 0, "perr_init");
      @(posedge clk); #1;
      cfg_latency     = 4'd5;
      bus.slave_req   = 1'b1;
      bus.slave_cmd   = CMD_WR;
      bus.slave_addr  = 32'h30;
      bus.slave_wdata = 32'h0BAD_0BAD;
      acks = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.slave_ack === 1'b1) acks++;
         @(posedge clk);
      end
      #1;
      bus.slave_req = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.slave_ack === 1'b1) acks++;
      end
      exp_err = 1'b1;
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL proto_err ack: got %0d acks expected 0", acks);
      end
      check_counters("proto_err");
      do_txn(CMD_RD, 32'h30, '0, 1, "perr_readback");
      do_txn(CMD_RD, 32'h30, '0, 0, "perr_sticky");
   endtask

   task automatic test_back_to_back();
      int    req_cyc, acks, n;
      int    ack_cyc [3];
      data_t rd [3];
      do_txn(CMD_WR, 32'h20, 32'hA5A5_2020, 0, "b2b_init");
      @(posedge clk); #1;
      cfg_latency    = 4'd1;
      bus.slave_req  = 1'b1;
      bus.slave_cmd  = CMD_RD;
      bus.slave_addr = 32'h20;
      req_cyc = cyc;
      acks = 0;
      n = 0;
      while (acks < 3 && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.slave_ack === 1'b1) begin
            ack_cyc[acks] = cyc;
            rd[acks]      = bus.slave_rdata;
            acks++;
         end
      end
      @(posedge clk); #1;
      bus.slave_req = 1'b0;
      checks++;
      if (acks != 3) begin
         errors++;
         $display("FAIL b2b ack count: got %0d expected 3", acks);
      end else begin
         exp_rd += 3;
         checks++;
         if (ack_cyc[0] - req_cyc != 2 || ack_cyc[1] - ack_cyc[0] != 3 ||
             ack_cyc[2] - ack_cyc[1] != 3) begin
            errors++;
            $display("FAIL b2b spacing: got %0d/%0d/%0d expected 2/3/3", ack_cyc[0] - req_cyc,
                     ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd[i] !== ref_mem[idx_of(32'h20)]) begin
               errors++;
               $display("FAIL b2b rdata[%0d]: got %h expected %h", i, rd[i],
                        ref_mem[idx_of(32'h20)]);
            end
         end
      end
      @(negedge clk);
      check_counters("b2b");
   endtask

   task automatic test_reset_mid();
      do_txn(CMD_WR, 32'h40, 32'h1111_4040, 0, "rst_init");
      @(posedge clk); #1;
      cfg_latency     = 4'd10;
      bus.slave_req   = 1'b1;
      bus.slave_cmd   = CMD_WR;
      bus.slave_addr  = 32'h40;
      bus.slave_wdata = 32'h9999_9999;
      repeat (3) @(posedge clk);
      #1;
      aresetn = 1'b0;
      #1;
      exp_wr = 0;
      exp_rd = 0;
      exp_err = 1'b0;
      checks++;
      if (bus.slave_ack !== 1'b0 || bus.slave_rdata !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs: ack=%0b rdata=%h expected 0/0", bus.slave_ack,
                  bus.slave_rdata);
      end
      check_counters("reset_mid");
      bus.slave_req = 1'b0;
      @(posedge clk); #1;
      aresetn = 1'b1;
      do_txn(CMD_RD, 32'h40, '0, 2, "rst_readback");
      do_txn(CMD_RD, 32'h10, '0, 0, "rst_readback_old");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_latency();
      test_alias();
      test_random();
      test_proto_err();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
